// File: rtl/output_port.sv
// output_port: buffered router link transmitter with on/off flow control and framing check.
// Ports: clk; rst (asynchronous, active-low); data_i/valid_flit_i from the crossbar;
// on_off_i from the downstream input port (1 = may send); data_o/valid_flit_o onto the link;
// is_full_o/is_empty_o fullness to the switch allocator; error_o sticky overflow/framing error;
// stall_cnt_o cycles spent holding flits while blocked.
// Flit layout: {flit_label[1:0], payload[DATA_W-1:0]}, label HEAD=0 BODY=1 TAIL=2 HEADTAIL=3.
// Optional: define OUTPUT_PORT_STALL_CNT_EN to build the saturating stall counter (else tied to 0).
module output_port #(
  parameter int BUFFER_SIZE = 8,
  parameter int STALL_CNT_W = 16,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W+1:0]      data_i,
  input  logic                   valid_flit_i,
  input  logic                   on_off_i,
  output logic [DATA_W+1:0]      data_o,
  output logic                   valid_flit_o,
  output logic                   is_full_o,
  output logic                   is_empty_o,
  output logic                   error_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3;
  typedef enum logic {IDLE, IN_PACKET} state_t;
  state_t state, state_n;
  logic [DATA_W+1:0] mem [BUFFER_SIZE];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic rd, wr, frame_err;
  logic [1:0] lbl;
  assign is_empty_o = count == '0;
  assign is_full_o  = count == (AW+1)'(BUFFER_SIZE);
  // on_off_i is used unregistered; the downstream threshold already covers the round trip
  assign rd  = !is_empty_o && on_off_i;
  // a write into a full FIFO is still legal when the head leaves in the same cycle
  assign wr  = valid_flit_i && (!is_full_o || rd);
  assign lbl = mem[rd_ptr][DATA_W+1 -: 2];
  // framing is checked on the flit leaving now; HEAD/HEADTAIL always restart a packet
  always_comb begin
    state_n   = !rd ? state : lbl == HEAD ? IN_PACKET : lbl == BODY ? state : IDLE;
    frame_err = rd && (state == IDLE ? (lbl == BODY || lbl == TAIL) : (lbl == HEAD || lbl == HEADTAIL));
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      data_o       <= '0;
      valid_flit_o <= 1'b0;
      error_o      <= 1'b0;
      state        <= IDLE;
    end else begin
      rd_ptr       <= rd_ptr + AW'(rd);
      wr_ptr       <= wr_ptr + AW'(wr);
      count        <= count + (AW+1)'(wr) - (AW+1)'(rd);
      data_o       <= rd ? mem[rd_ptr] : data_o;
      valid_flit_o <= rd;
      error_o      <= error_o || frame_err || (valid_flit_i && !wr);
      state        <= state_n;
    end
`ifdef OUTPUT_PORT_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt_o <= '0;
    else if (!is_empty_o && !on_off_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_output_port.sv
// tb_output_port: randomized self-checking bench for output_port against a queue-based model.
module tb_output_port;
  localparam int BS = 8;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int FW = DW + 2;
  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3;
`ifdef OUTPUT_PORT_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic valid_flit_i = 1'b0;
  logic on_off_i = 1'b0;
  logic [FW-1:0] data_o;
  logic valid_flit_o, is_full_o, is_empty_o, error_o;
  logic [SW-1:0] stall_cnt_o;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  // model state
  logic [FW-1:0] m_q[$];
  logic [FW-1:0] m_data;
  logic m_valid, m_err, m_open;
  logic [SW-1:0] m_stall;
  logic g_open;

  output_port #(.BUFFER_SIZE(BS), .STALL_CNT_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i), .on_off_i(on_off_i),
    .data_o(data_o), .valid_flit_o(valid_flit_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
    .error_o(error_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_open = 1'b0;
    m_stall = '0;
    g_open = 1'b0;
  endtask

  // One clock of the specified behaviour, using the state before the edge.
  task automatic model_step(input logic v, input logic [FW-1:0] d, input logic on);
    logic send, take;
    logic [1:0] l;
    send = m_q.size() != 0 && on;
    take = v && (m_q.size() < BS || send);
    if (STALL_EN && m_q.size() != 0 && !on && m_stall != '1) m_stall = m_stall + 1'b1;
    m_valid = send;
    if (send) begin
      m_data = m_q.pop_front();
      l = m_data[FW-1 -: 2];
      // body/tail need an open packet; a head must not arrive inside one
      if ((l == BODY || l == TAIL) && !m_open) m_err = 1'b1;
      if ((l == HEAD || l == HEADTAIL) && m_open) m_err = 1'b1;
      if (l == HEAD) m_open = 1'b1;
      else if (l != BODY) m_open = 1'b0;
    end
    if (take) m_q.push_back(d);
    else if (v) m_err = 1'b1;
  endtask

  task automatic tick(input logic v, input logic [FW-1:0] d, input logic on);
    valid_flit_i = v;
    data_i = d;
    on_off_i = on;
    @(posedge clk);
    model_step(v, d, on);
    @(negedge clk);
    cyc++;
  endtask

  task automatic next_flit(output logic [FW-1:0] f);
    logic [1:0] l;
    l = g_open ? 2'($urandom_range(1, 2)) : ($urandom_range(0, 1) != 0 ? HEAD : HEADTAIL);
    g_open = (l == HEAD) || (l == BODY);
    f = {l, DW'($urandom)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    valid_flit_i = 1'b0;
    on_off_i = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    #3;
    total++;
    if ({data_o, valid_flit_o, is_full_o, is_empty_o, error_o, stall_cnt_o} !== {{FW{1'b0}}, 4'b0010, {SW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_values got d=%h v=%b f=%b e=%b err=%b st=%0d want d=0 v=0 f=0 e=1 err=0 st=0",
               data_o, valid_flit_o, is_full_o, is_empty_o, error_o, stall_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    do_reset();
    f = {HEADTAIL, DW'($urandom)};
    tick(1'b1, f, 1'b1);
    total++;
    if (valid_flit_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_cycle1_valid got %b want 0", valid_flit_o);
    end
    tick(1'b0, '0, 1'b1);
    total++;
    if ({valid_flit_o, data_o, is_empty_o, error_o} !== {1'b1, f, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL basic_send got v=%b d=%h e=%b err=%b want v=1 d=%h e=1 err=0",
               valid_flit_o, data_o, is_empty_o, error_o, f);
    end
  endtask

  task automatic fill_packet();
    for (int i = 0; i < BS; i++)
      tick(1'b1, {(i == 0 ? HEAD : i == BS - 1 ? TAIL : BODY), DW'($urandom)}, 1'b0);
  endtask

  task automatic test_full_drain();
    int sent = 0;
    do_reset();
    fill_packet();
    total++;
    if ({is_full_o, is_empty_o, error_o} !== 3'b100) begin
      bad++;
      $display("FAIL full_after_8 got f=%b e=%b err=%b want f=1 e=0 err=0", is_full_o, is_empty_o, error_o);
    end
    for (int i = 0; i < BS + 1; i++) begin
      tick(1'b0, '0, 1'b1);
      sent += int'(valid_flit_o);
      total++;
      if ({valid_flit_o, data_o, is_full_o, is_empty_o, error_o} !== {m_valid, m_data, m_q.size() == BS, m_q.size() == 0, m_err}) begin
        bad++;
        $display("FAIL drain cyc=%0d got v=%b d=%h f=%b e=%b err=%b want v=%b d=%h f=%b e=%b err=%b", cyc,
                 valid_flit_o, data_o, is_full_o, is_empty_o, error_o, m_valid, m_data, m_q.size() == BS, m_q.size() == 0, m_err);
      end
    end
    total++;
    if (sent != BS || is_empty_o !== 1'b1) begin
      bad++;
      $display("FAIL drain_count got sent=%0d e=%b want sent=%0d e=1", sent, is_empty_o, BS);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_packet();
    tick(1'b1, {BODY, DW'($urandom)}, 1'b0);
    total++;
    if ({error_o, is_full_o} !== 2'b11) begin
      bad++;
      $display("FAIL overflow_err got err=%b f=%b want err=1 f=1", error_o, is_full_o);
    end
    for (int i = 0; i < BS + 1; i++) begin
      tick(1'b0, '0, 1'b1);
      total++;
      if ({valid_flit_o, data_o, is_empty_o, error_o} !== {m_valid, m_data, m_q.size() == 0, m_err}) begin
        bad++;
        $display("FAIL overflow_drain cyc=%0d got v=%b d=%h e=%b err=%b want v=%b d=%h e=%b err=%b", cyc,
                 valid_flit_o, data_o, is_empty_o, error_o, m_valid, m_data, m_q.size() == 0, m_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < BS; i++) begin
      next_flit(f);
      tick(1'b1, f, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      next_flit(f);
      tick(1'b1, f, 1'b1);
      total++;
      if ({valid_flit_o, data_o, is_full_o, error_o} !== {1'b1, m_data, 1'b1, 1'b0} || m_err) begin
        bad++;
        $display("FAIL full_concurrent cyc=%0d got v=%b d=%h f=%b err=%b want v=1 d=%h f=1 err=0", cyc,
                 valid_flit_o, data_o, is_full_o, error_o, m_data);
      end
    end
  endtask

  task automatic test_framing();
    do_reset();
    tick(1'b1, {BODY, DW'($urandom)}, 1'b1);
    tick(1'b0, '0, 1'b1);
    total++;
    if ({valid_flit_o, error_o} !== 2'b11) begin
      bad++;
      $display("FAIL frame_body_idle got v=%b err=%b want v=1 err=1", valid_flit_o, error_o);
    end
    do_reset();
    tick(1'b1, {HEAD, DW'($urandom)}, 1'b1);
    tick(1'b1, {HEAD, DW'($urandom)}, 1'b1);
    total++;
    if ({valid_flit_o, error_o} !== 2'b10) begin
      bad++;
      $display("FAIL frame_first_head got v=%b err=%b want v=1 err=0", valid_flit_o, error_o);
    end
    tick(1'b0, '0, 1'b1);
    total++;
    if ({valid_flit_o, error_o} !== 2'b11) begin
      bad++;
      $display("FAIL frame_head_head got v=%b err=%b want v=1 err=1", valid_flit_o, error_o);
    end
  endtask

  task automatic test_midreset();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_flit(f);
      tick(1'b1, f, 1'b0);
    end
    tick(1'b0, '0, 1'b1);
    total++;
    if (valid_flit_o !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre got v=%b want 1", valid_flit_o);
    end
    #1 rst = 1'b0;
    model_clear();
    #1;
    total++;
    if ({valid_flit_o, is_empty_o, is_full_o, error_o, stall_cnt_o} !== {4'b0100, {SW{1'b0}}}) begin
      bad++;
      $display("FAIL midreset got v=%b e=%b f=%b err=%b st=%0d want v=0 e=1 f=0 err=0 st=0",
               valid_flit_o, is_empty_o, is_full_o, error_o, stall_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, '0, 1'b1);
    total++;
    if ({valid_flit_o, is_empty_o} !== 2'b01) begin
      bad++;
      $display("FAIL midreset_after got v=%b e=%b want v=0 e=1", valid_flit_o, is_empty_o);
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_flit(f);
      tick(1'b1, f, 1'b0);
    end
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b0);
    total++;
    // four blocked cycles while filling plus ten idle ones
    if (stall_cnt_o !== m_stall || m_stall !== SW'(STALL_EN ? 14 : 0)) begin
      bad++;
      $display("FAIL stall_count got %0d want %0d", stall_cnt_o, m_stall);
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      next_flit(f);
      if ($urandom_range(0, 19) == 0) f[FW-1 -: 2] = 2'($urandom);
      tick($urandom_range(0, 9) < 7, f, $urandom_range(0, 9) < 6);
      total++;
      if ({valid_flit_o, data_o, is_full_o, is_empty_o, error_o, stall_cnt_o} !==
          {m_valid, m_data, m_q.size() == BS, m_q.size() == 0, m_err, m_stall}) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b d=%h f=%b e=%b err=%b st=%0d want v=%b d=%h f=%b e=%b err=%b st=%0d", cyc,
                 valid_flit_o, data_o, is_full_o, is_empty_o, error_o, stall_cnt_o,
                 m_valid, m_data, m_q.size() == BS, m_q.size() == 0, m_err, m_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_drain();
    test_overflow();
    test_back_to_back();
    test_framing();
    test_midreset();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
